// File: rtl/debounce_edge.sv
// rtl/debounce_edge.sv - Debounce filter with press/release/hold strobes
//
// Turns a synchronized but still bouncy switch level into a clean debounced
// "pressed" level plus one-cycle press/release strobes. A level change is
// accepted only after DEBOUNCE_CYCLES consecutive identical samples.
//
// Optional feature macro: DEBOUNCE_EDGE_HOLD_EN (long-press HOLD_PULSE).
// With the macro undefined HOLD_PULSE is tied to 0 and no hold logic exists.
//
// Ports:
//   CLK            in   system clock, rising edge
//   RST_N          in   asynchronous active-low reset
//   SYNC_IN        in   synchronized raw switch level
//   PRESSED        out  debounced level, 1 = pressed
//   PRESS_PULSE    out  one-cycle strobe on accepted press
//   RELEASE_PULSE  out  one-cycle strobe on accepted release
//   HOLD_PULSE     out  one-cycle strobe on long press (optional feature)
//   BUSY           out  1 while a level change is being qualified

module debounce_edge #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter bit IDLE_LEVEL      = 1'b1,
  parameter int HOLD_CYCLES     = 1000
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic SYNC_IN,
  output logic PRESSED,
  output logic PRESS_PULSE,
  output logic RELEASE_PULSE,
  output logic HOLD_PULSE,
  output logic BUSY
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  if (DEBOUNCE_CYCLES < 2 || HOLD_CYCLES < 1) begin : g_bad_param
    $error("debounce_edge: DEBOUNCE_CYCLES must be >= 2 and HOLD_CYCLES >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESS_WAIT,
    S_PRESSED,
    S_RELEASE_WAIT
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pressed_q, pressed_d;
  logic             press_pulse_q, press_pulse_d;
  logic             release_pulse_q, release_pulse_d;
  logic             busy_q, busy_d;
  logic             act;

  assign act = (SYNC_IN != IDLE_LEVEL);

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    pressed_d       = pressed_q;
    press_pulse_d   = 1'b0;
    release_pulse_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (act) begin
          state_d = S_PRESS_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      S_PRESS_WAIT: begin
        if (!act) begin
          // Bounce: drop back silently.
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d       = S_PRESSED;
          cnt_d         = '0;
          pressed_d     = 1'b1;
          press_pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_PRESSED: begin
        if (!act) begin
          state_d = S_RELEASE_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      S_RELEASE_WAIT: begin
        if (act) begin
          // Release bounce: still pressed, no strobe.
          state_d = S_PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d         = S_IDLE;
          cnt_d           = '0;
          pressed_d       = 1'b0;
          release_pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d == S_PRESS_WAIT) || (state_d == S_RELEASE_WAIT);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      pressed_q       <= 1'b0;
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      pressed_q       <= pressed_d;
      press_pulse_q   <= press_pulse_d;
      release_pulse_q <= release_pulse_d;
      busy_q          <= busy_d;
    end
  end

  assign PRESSED       = pressed_q;
  assign PRESS_PULSE   = press_pulse_q;
  assign RELEASE_PULSE = release_pulse_q;
  assign BUSY          = busy_q;

`ifdef DEBOUNCE_EDGE_HOLD_EN
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);

  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              hold_pulse_q, hold_pulse_d;

  always_comb begin
    hold_cnt_d   = hold_cnt_q;
    hold_pulse_d = 1'b0;
    if (state_q == S_PRESS_WAIT && state_d == S_PRESSED) begin
      hold_cnt_d = '0;
    end else if ((state_q == S_PRESSED || state_q == S_RELEASE_WAIT) &&
                 (hold_cnt_q < HOLD_MAX)) begin
      // Saturates at HOLD_MAX, so the strobe fires once per accepted press.
      hold_cnt_d = hold_cnt_q + HOLD_W'(1);
      if (hold_cnt_d == HOLD_MAX) begin
        hold_pulse_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      hold_cnt_q   <= '0;
      hold_pulse_q <= 1'b0;
    end else begin
      hold_cnt_q   <= hold_cnt_d;
      hold_pulse_q <= hold_pulse_d;
    end
  end

  assign HOLD_PULSE = hold_pulse_q;
`else
  assign HOLD_PULSE = 1'b0;
`endif

endmodule
